async_fifo_reader: RTL and testbench
====================================

// Module: async_fifo_reader
// PURPOSE
//   Read-side controller for async_fifo, in the rd_clk domain. On start it drains NUM_WORDS words.
//   Drives rd_en from empty at up to 1 word/cycle and stores each word in a capture RAM.
//   Keeps a running 16-bit checksum and word count; the bench reads captured words back by address.
// PARAMETERS
//   DATA_W     16  FIFO data width (matches data_out_fifo)
//   CAP_AW     5   capture RAM address width; depth = 2**CAP_AW
//   NUM_WORDS  32  words read per start; legal range 1..2**CAP_AW
// PORTS
//   rd_clk         in   1       read clock, rising edge; sole clock
//   reset_n        in   1       asynchronous, active-low reset
//   start          in   1       1-cycle pulse; begins a drain, honoured only in IDLE or DONE
//   empty          in   1       FIFO empty flag (rd_clk domain)
//   data_out_fifo  in   DATA_W  FIFO read data, valid the cycle after rd_en sampled high
//   rd_en          out  1       FIFO read enable
//   cap_addr       in   CAP_AW  capture RAM readback address
//   cap_data       out  DATA_W  capture RAM word at cap_addr, registered, 1-cycle latency
//   word_count     out  CAP_AW+1  words captured since last start
//   checksum       out  DATA_W  modulo-2**DATA_W sum of captured words
//   busy           out  1       high in RUN and DRAIN
//   done           out  1       high in DONE
// BEHAVIOUR
//   Reset values
//   - Reset (reset_n=0, any cycle, incl. mid-drain): state=IDLE, rd_en=0, word_count=0,
//     checksum=0, cap_data=0, busy=0, done=0, internal issue count=0.
//   - RAM contents are not reset. Reads of unwritten addresses return undefined data.
//   rd_en
//   - Combinational: rd_en = (state==RUN) && !empty && issued<NUM_WORDS (&& gap==0 if throttled).
//   - rd_en is never high while empty=1. An underflowing read is impossible by construction.
//   Capture pipeline
//   - cap_vld register = rd_en, delayed 1 cycle.
//   - When cap_vld=1: RAM[word_count] <= data_out_fifo; checksum += data_out_fifo (wraps);
//     word_count += 1.
//   FSM
//   - IDLE  -start-> RUN. Start clears word_count, checksum and issued.
//   - RUN   -issued reaches NUM_WORDS (on the rd_en cycle)-> DRAIN.
//   - DRAIN -1 cycle, last capture done-> DONE.
//   - DONE  -start-> RUN (same clears as IDLE). Otherwise holds.
//   - start in RUN or DRAIN is ignored.
//   Flow and boundaries
//   - RUN with empty=1: stall with rd_en=0, no timeout. Resumes the cycle empty falls.
//   - Back-to-back reads: NUM_WORDS words with empty=0 throughout take NUM_WORDS cycles in RUN.
//     done rises NUM_WORDS+2 cycles after the start pulse.
//   - word_count reaches NUM_WORDS exactly, then never wraps. RAM index = word_count[CAP_AW-1:0].
//   - Readback via cap_addr works in every state. A same-cycle write to the same address
//     returns the old data.
//   - start coincident with reset_n=0: reset wins.
// CONFIGURATION
//   `define FIFO_READER_THROTTLE_EN
//   - Adds input port rd_gap [3:0], sampled at start.
//   - After each rd_en pulse a gap counter loads rd_gap and holds rd_en=0 for rd_gap cycles.
//   - rd_gap=0 is identical to unthrottled operation. Used to back-pressure the writer and
//     exercise full.
//   Undefined: port absent, gap logic removed, reads back-to-back whenever !empty.
// TESTING
//   1. reset_n=0 mid-RUN after 5 words -> rd_en=0 same cycle, word_count=0, checksum=0,
//      state IDLE, busy=0.
//   2. FIFO preloaded with 32 words 0x0001..0x0020, pulse start -> rd_en high 32 consecutive
//      cycles, done at cycle 34, word_count=32, checksum=0x0210, cap_addr=7 -> cap_data=0x0008.
//   3. empty toggles 1/0 every 3 cycles during RUN -> rd_en=0 whenever empty=1; data in RAM in
//      FIFO order; count still 32.
//   4. Data 0xFFFF,0x0002 with NUM_WORDS=2 -> checksum=0x0001 (wrap), done after 4 cycles.
//   5. start pulsed in RUN, then again in DONE -> first pulse ignored; second clears
//      count/checksum and re-drains.
//   6. FIFO_READER_THROTTLE_EN, rd_gap=3, FIFO full -> rd_en pulses every 4th cycle,
//      full deasserts after first read.

Source files
------------

// File: rtl/async_fifo_reader.sv
// async_fifo_reader: read-side drain controller for async_fifo (rd_clk domain).
// On start it reads NUM_WORDS words from the FIFO into a capture RAM. It also
// keeps a running checksum and word count. The RAM can be read back through
// cap_addr at any time.
// Optional feature macro: FIFO_READER_THROTTLE_EN adds an rd_gap input. rd_gap
// inserts idle cycles between reads. Without the macro the block reads back-to-back
// whenever the FIFO is not empty.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | after reset, waiting for start
// RUN   | issuing rd_en until NUM_WORDS reads have been issued
// DRAIN | one cycle for the final captured word to land
// DONE  | drain complete, results held until the next start

module async_fifo_reader #(
    parameter int DATA_W    = 16,
    parameter int CAP_AW    = 5,
    parameter int NUM_WORDS = 32
) (
    input  logic              rd_clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              empty,
    input  logic [DATA_W-1:0] data_out_fifo,
`ifdef FIFO_READER_THROTTLE_EN
    input  logic [3:0]        rd_gap,
`endif
    output logic              rd_en,
    input  logic [CAP_AW-1:0] cap_addr,
    output logic [DATA_W-1:0] cap_data,
    output logic [CAP_AW:0]   word_count,
    output logic [DATA_W-1:0] checksum,
    output logic              busy,
    output logic              done
);

    localparam int                CNT_W    = CAP_AW + 1;
    localparam int                DEPTH    = 1 << CAP_AW;
    localparam logic [CNT_W-1:0]  NUM_CNT  = CNT_W'(NUM_WORDS);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  issued_q, issued_d;
    logic [CNT_W-1:0]  word_count_q, word_count_d;
    logic [DATA_W-1:0] checksum_q, checksum_d;
    logic              cap_vld_q, cap_vld_d;
    logic [DATA_W-1:0] cap_data_q, cap_data_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic start_ok;
    logic gap_ok;
    logic rd_issue;
    logic last_issue;

    // start only counts in IDLE or DONE; pulses during a drain are dropped
    always_comb begin
        start_ok = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    end

`ifdef FIFO_READER_THROTTLE_EN
    logic [3:0] rd_gap_q, rd_gap_d;
    logic [3:0] gap_q, gap_d;

    // Gap down-counter: loads the sampled rd_gap on every read, then blocks reads until it reaches zero
    always_comb begin
        rd_gap_d = rd_gap_q;
        gap_d    = gap_q;
        if (start_ok) begin
            rd_gap_d = rd_gap;
            gap_d    = 4'd0;
        end else if (rd_issue) begin
            gap_d = rd_gap_q;
        end else if (gap_q != 4'd0) begin
            gap_d = gap_q - 4'd1;
        end
        gap_ok = (gap_q == 4'd0);
    end

    // Throttle registers
    always_ff @(posedge rd_clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_gap_q <= 4'd0;
            gap_q    <= 4'd0;
        end else begin
            rd_gap_q <= rd_gap_d;
            gap_q    <= gap_d;
        end
    end
`else
    // Unthrottled: a read may be issued on every cycle
    always_comb begin
        gap_ok = 1'b1;
    end
`endif

    // Read issue: never reads while empty, and never reads more than NUM_WORDS
    always_comb begin
        rd_issue   = (state_q == ST_RUN) && !empty && (issued_q < NUM_CNT) && gap_ok;
        last_issue = rd_issue && ((issued_q + CNT_ONE) == NUM_CNT);
    end

    // State register
    always_ff @(posedge rd_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start_ok)   state_d = ST_RUN;
            ST_RUN:   if (last_issue) state_d = ST_DRAIN;
            ST_DRAIN:                 state_d = ST_DONE;
            ST_DONE:  if (start_ok)   state_d = ST_RUN;
            default:                  state_d = ST_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        rd_en = rd_issue;
        busy  = (state_q == ST_RUN) || (state_q == ST_DRAIN);
        done  = (state_q == ST_DONE);
    end

    // Capture datapath: a word returned by the FIFO is counted and summed one cycle after its rd_en
    always_comb begin
        issued_d     = issued_q;
        word_count_d = word_count_q;
        checksum_d   = checksum_q;
        cap_vld_d    = rd_issue;
        if (start_ok) begin
            issued_d     = '0;
            word_count_d = '0;
            checksum_d   = '0;
        end else begin
            if (rd_issue) begin
                issued_d = issued_q + CNT_ONE;
            end
            if (cap_vld_q) begin
                word_count_d = word_count_q + CNT_ONE;
                checksum_d   = checksum_q + data_out_fifo;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge rd_clk or negedge reset_n) begin
        if (!reset_n) begin
            issued_q     <= '0;
            word_count_q <= '0;
            checksum_q   <= '0;
            cap_vld_q    <= 1'b0;
        end else begin
            issued_q     <= issued_d;
            word_count_q <= word_count_d;
            checksum_q   <= checksum_d;
            cap_vld_q    <= cap_vld_d;
        end
    end

    // Capture RAM write port. It has no reset, so the storage stays plain RAM.
    always_ff @(posedge rd_clk) begin
        if (cap_vld_q) begin
            mem_q[word_count_q[CAP_AW-1:0]] <= data_out_fifo;
        end
    end

    // Readback port. It samples the RAM before this edge's write, so a same-address write returns the old word.
    always_comb begin
        cap_data_d = mem_q[cap_addr];
    end

    // Registered readback data
    always_ff @(posedge rd_clk or negedge reset_n) begin
        if (!reset_n) begin
            cap_data_q <= '0;
        end else begin
            cap_data_q <= cap_data_d;
        end
    end

    assign cap_data   = cap_data_q;
    assign word_count = word_count_q;
    assign checksum   = checksum_q;

endmodule

// File: tb/tb_async_fifo_reader.sv
// Directed testbench for async_fifo_reader.
// Instance A uses NUM_WORDS=32 and instance B uses NUM_WORDS=2. Each instance has a behavioural FIFO.
module tb_async_fifo_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;
    int   checks   = 0;
    int   failures = 0;

    // ---------------- instance A (32 words) ----------------
    logic        start_a, empty_a, rd_en_a, busy_a, done_a, hold_a;
    logic [15:0] dout_a, cap_data_a, checksum_a;
    logic [4:0]  cap_addr_a;
    logic [5:0]  wc_a;
    logic [15:0] fifo_a [256];
    logic [7:0]  wr_a, rd_a;
    logic        full_a;
`ifdef FIFO_READER_THROTTLE_EN
    logic [3:0]  rd_gap_a;
`endif

    assign empty_a = (wr_a == rd_a) || hold_a;
    assign full_a  = ((wr_a - rd_a) == 8'd16);

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_a   <= 8'd0;
            dout_a <= 16'd0;
        end else if (rd_en_a) begin
            dout_a <= fifo_a[rd_a];
            rd_a   <= rd_a + 8'd1;
        end
    end

    async_fifo_reader #(.DATA_W(16), .CAP_AW(5), .NUM_WORDS(32)) dut_a (
        .rd_clk        (clk),
        .reset_n       (reset_n),
        .start         (start_a),
        .empty         (empty_a),
        .data_out_fifo (dout_a),
`ifdef FIFO_READER_THROTTLE_EN
        .rd_gap        (rd_gap_a),
`endif
        .rd_en         (rd_en_a),
        .cap_addr      (cap_addr_a),
        .cap_data      (cap_data_a),
        .word_count    (wc_a),
        .checksum      (checksum_a),
        .busy          (busy_a),
        .done          (done_a)
    );

    // ---------------- instance B (2 words) ----------------
    logic        start_b, empty_b, rd_en_b, busy_b, done_b;
    logic [15:0] dout_b, cap_data_b, checksum_b;
    logic [4:0]  cap_addr_b;
    logic [5:0]  wc_b;
    logic [15:0] fifo_b [256];
    logic [7:0]  wr_b, rd_b;
`ifdef FIFO_READER_THROTTLE_EN
    logic [3:0]  rd_gap_b;
`endif

    assign empty_b = (wr_b == rd_b);

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_b   <= 8'd0;
            dout_b <= 16'd0;
        end else if (rd_en_b) begin
            dout_b <= fifo_b[rd_b];
            rd_b   <= rd_b + 8'd1;
        end
    end

    async_fifo_reader #(.DATA_W(16), .CAP_AW(5), .NUM_WORDS(2)) dut_b (
        .rd_clk        (clk),
        .reset_n       (reset_n),
        .start         (start_b),
        .empty         (empty_b),
        .data_out_fifo (dout_b),
`ifdef FIFO_READER_THROTTLE_EN
        .rd_gap        (rd_gap_b),
`endif
        .rd_en         (rd_en_b),
        .cap_addr      (cap_addr_b),
        .cap_data      (cap_data_b),
        .word_count    (wc_b),
        .checksum      (checksum_b),
        .busy          (busy_b),
        .done          (done_b)
    );

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n    = 1'b0;
        start_a    = 1'b0;
        start_b    = 1'b0;
        hold_a     = 1'b0;
        wr_a       = 8'd0;
        wr_b       = 8'd0;
        cap_addr_a = 5'd0;
        cap_addr_b = 5'd0;
`ifdef FIFO_READER_THROTTLE_EN
        rd_gap_a   = 4'd0;
        rd_gap_b   = 4'd0;
`endif
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic load_a(input logic [15:0] base, input logic [15:0] step, input int n);
        for (int i = 0; i < n; i++) begin
            fifo_a[wr_a] = base + step * 16'(i);
            wr_a         = wr_a + 8'd1;
        end
    endtask

    // Leaves the bench in cycle 1, the first cycle after the start edge.
    task automatic pulse_start_a();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        reset_n = 1'b0;
        tick();
        checks++;
        if (rd_en_a !== 1'b0 || busy_a !== 1'b0 || done_a !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl rd_en=%b busy=%b done=%b exp 0/0/0", rd_en_a, busy_a, done_a);
        end
        checks++;
        if (wc_a !== 6'd0 || checksum_a !== 16'd0 || cap_data_a !== 16'd0) begin
            failures++;
            $display("FAIL reset_data wc=%0d sum=%h cap=%h exp 0/0000/0000", wc_a, checksum_a, cap_data_a);
        end
        reset_n = 1'b1;
        load_a(16'h0001, 16'h0001, 4);
        tick();
        tick();
        checks++;
        if (rd_en_a !== 1'b0 || busy_a !== 1'b0) begin
            failures++;
            $display("FAIL idle_no_read rd_en=%b busy=%b exp 0/0", rd_en_a, busy_a);
        end
    endtask

    task automatic test_reset_mid_run();
        do_reset();
        load_a(16'h0001, 16'h0001, 32);
        pulse_start_a();
        for (int i = 0; i < 6; i++) tick();
        checks++;
        if (wc_a !== 6'd5 || busy_a !== 1'b1 || rd_en_a !== 1'b1) begin
            failures++;
            $display("FAIL midrun_pre wc=%0d busy=%b rd_en=%b exp 5/1/1", wc_a, busy_a, rd_en_a);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (rd_en_a !== 1'b0 || wc_a !== 6'd0 || checksum_a !== 16'd0 || busy_a !== 1'b0 || done_a !== 1'b0) begin
            failures++;
            $display("FAIL midrun_reset rd_en=%b wc=%0d sum=%h busy=%b done=%b exp 0/0/0000/0/0",
                     rd_en_a, wc_a, checksum_a, busy_a, done_a);
        end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        do_reset();
        load_a(16'h0001, 16'h0001, 32);
        pulse_start_a();
        for (int cyc = 1; cyc <= 40; cyc++) begin
            checks++;
            if (rd_en_a !== (cyc <= 32) || done_a !== (cyc >= 34) || busy_a !== (cyc <= 33)) begin
                failures++;
                $display("FAIL b2b_cycle%0d rd_en=%b done=%b busy=%b exp %b/%b/%b", cyc, rd_en_a, done_a,
                         busy_a, (cyc <= 32), (cyc >= 34), (cyc <= 33));
            end
            tick();
        end
        checks++;
        if (wc_a !== 6'd32 || checksum_a !== 16'h0210) begin
            failures++;
            $display("FAIL b2b_totals wc=%0d sum=%h exp 32/0210", wc_a, checksum_a);
        end
        cap_addr_a = 5'd7;
        tick();
        checks++;
        if (cap_data_a !== 16'h0008) begin
            failures++;
            $display("FAIL b2b_addr7 got %h exp 0008", cap_data_a);
        end
        for (int i = 0; i < 32; i++) begin
            cap_addr_a = 5'(i);
            tick();
            checks++;
            if (cap_data_a !== 16'(i + 1)) begin
                failures++;
                $display("FAIL b2b_ram[%0d] got %h exp %h", i, cap_data_a, 16'(i + 1));
            end
        end
    endtask

    task automatic test_stall();
        int issued;
        logic exp;
        issued = 0;
        do_reset();
        load_a(16'h0100, 16'h0001, 32);
        pulse_start_a();
        for (int cyc = 1; cyc <= 120; cyc++) begin
            hold_a = (((cyc - 1) / 3) % 2 == 0);
            #1;
            exp = !hold_a && (issued < 32);
            checks++;
            if (rd_en_a !== exp) begin
                failures++;
                $display("FAIL stall_cycle%0d rd_en=%b exp %b (empty=%b)", cyc, rd_en_a, exp, empty_a);
            end
            if (exp) issued++;
            tick();
        end
        hold_a = 1'b0;
        tick();
        checks++;
        if (done_a !== 1'b1 || wc_a !== 6'd32) begin
            failures++;
            $display("FAIL stall_totals done=%b wc=%0d exp 1/32", done_a, wc_a);
        end
        for (int i = 0; i < 32; i += 5) begin
            cap_addr_a = 5'(i);
            tick();
            checks++;
            if (cap_data_a !== 16'h0100 + 16'(i)) begin
                failures++;
                $display("FAIL stall_ram[%0d] got %h exp %h", i, cap_data_a, 16'h0100 + 16'(i));
            end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        fifo_b[0] = 16'hFFFF;
        fifo_b[1] = 16'h0002;
        wr_b      = 8'd2;
        start_b   = 1'b1;
        tick();
        start_b   = 1'b0;
        for (int cyc = 1; cyc <= 6; cyc++) begin
            checks++;
            if (rd_en_b !== (cyc <= 2) || done_b !== (cyc >= 4)) begin
                failures++;
                $display("FAIL wrap_cycle%0d rd_en=%b done=%b exp %b/%b", cyc, rd_en_b, done_b,
                         (cyc <= 2), (cyc >= 4));
            end
            tick();
        end
        checks++;
        if (checksum_b !== 16'h0001 || wc_b !== 6'd2) begin
            failures++;
            $display("FAIL wrap_totals sum=%h wc=%0d exp 0001/2", checksum_b, wc_b);
        end
    endtask

    task automatic test_restart();
        do_reset();
        load_a(16'h0000, 16'h0003, 32);
        pulse_start_a();
        for (int cyc = 1; cyc <= 40; cyc++) begin
            start_a = (cyc == 10);
            #1;
            checks++;
            if (done_a !== (cyc >= 34)) begin
                failures++;
                $display("FAIL restart_run_cycle%0d done=%b exp %b", cyc, done_a, (cyc >= 34));
            end
            tick();
        end
        start_a = 1'b0;
        checks++;
        if (wc_a !== 6'd32 || checksum_a !== 16'h05D0) begin
            failures++;
            $display("FAIL restart_first wc=%0d sum=%h exp 32/05D0", wc_a, checksum_a);
        end
        load_a(16'h1000, 16'h0001, 32);
        pulse_start_a();
        checks++;
        if (wc_a !== 6'd0 || checksum_a !== 16'h0000 || busy_a !== 1'b1 || done_a !== 1'b0) begin
            failures++;
            $display("FAIL restart_clear wc=%0d sum=%h busy=%b done=%b exp 0/0000/1/0", wc_a, checksum_a,
                     busy_a, done_a);
        end
        for (int cyc = 2; cyc <= 40; cyc++) tick();
        checks++;
        if (done_a !== 1'b1 || wc_a !== 6'd32 || checksum_a !== 16'h01F0) begin
            failures++;
            $display("FAIL restart_second done=%b wc=%0d sum=%h exp 1/32/01F0", done_a, wc_a, checksum_a);
        end
        cap_addr_a = 5'd0;
        tick();
        checks++;
        if (cap_data_a !== 16'h1000) begin
            failures++;
            $display("FAIL restart_ram0 got %h exp 1000", cap_data_a);
        end
    endtask

`ifdef FIFO_READER_THROTTLE_EN
    task automatic test_throttle();
        do_reset();
        load_a(16'h0001, 16'h0001, 16);
        rd_gap_a = 4'd3;
        checks++;
        if (full_a !== 1'b1) begin
            failures++;
            $display("FAIL thr_full_pre got %b exp 1", full_a);
        end
        pulse_start_a();
        for (int cyc = 1; cyc <= 20; cyc++) begin
            checks++;
            if (rd_en_a !== ((cyc - 1) % 4 == 0)) begin
                failures++;
                $display("FAIL thr_cycle%0d rd_en=%b exp %b", cyc, rd_en_a, ((cyc - 1) % 4 == 0));
            end
            tick();
            if (cyc == 1) begin
                checks++;
                if (full_a !== 1'b0) begin
                    failures++;
                    $display("FAIL thr_full_post got %b exp 0", full_a);
                end
            end
        end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_reset_mid_run();
        test_back_to_back();
        test_stall();
        test_wrap();
        test_restart();
`ifdef FIFO_READER_THROTTLE_EN
        test_throttle();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
